des_key_schedule: RTL and testbench

- Sequential DES key-schedule generator. Sits directly downstream of the 64→56 PC-1 compression stage and consumes its 56-bit permuted key.
- Splits the key into C/D 28-bit halves, applies the per-round left rotations (or right rotations in decrypt mode) and the PC-2 56→48 compression.
- Streams the 16 round subkeys, one per accepted handshake, to the round-function datapath.

---
 rtl/des_key_schedule.sv | 133 +++++++++++++
 tb/tb_des_key_schedule.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
// DES key-schedule generator.
// Takes the 56-bit PC-1 output, keeps the C/D halves in registers and streams
// the 16 round subkeys (PC-2 of C||D) through a valid/ready handshake.
// Bit numbering: DES bit 1 (the MSB) maps to the highest vector index, so
// key bit n is key_sched_key_i[56-n] and subkey bit n is key_sched_subkey_o[48-n].
module des_key_schedule (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_sched_start_i,
   input  logic        key_sched_decrypt_i,
   input  logic [55:0] key_sched_key_i,
   input  logic        key_sched_ready_i,
   output logic [47:0] key_sched_subkey_o,
   output logic        key_sched_valid_o,
   output logic [3:0]  key_sched_round_o,
   output logic        key_sched_busy_o,
   output logic        key_sched_done_o
);

   typedef enum logic {
      IDLE = 1'b0,
      GEN  = 1'b1
   } state_t;

   // PC-2 selection table: entry i is the C||D bit (1-based) feeding subkey bit i+1.
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   state_t      state_q, state_d;
   logic [27:0] c_q, c_d;
   logic [27:0] d_q, d_d;
   logic [3:0]  round_q, round_d;
   logic        mode_q, mode_d;
   logic        done_q, done_d;

   logic [3:0]  next_idx;
   logic        single_step;
   logic [55:0] cd;

   function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
      return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
   endfunction

   function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
      return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
   endfunction

   // State, key halves, round counter, mode and done pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         c_q     <= '0;
         d_q     <= '0;
         round_q <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         round_q <= round_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: key capture on start, per-handshake rotation, end of run
   always_comb begin
      state_d     = state_q;
      c_d         = c_q;
      d_d         = d_q;
      round_d     = round_q;
      mode_d      = mode_q;
      done_d      = 1'b0;
      next_idx    = round_q + 4'd1;
      // Emission indices 1, 8 and 15 take a single-position step in both modes.
      single_step = (next_idx == 4'd1) || (next_idx == 4'd8) || (next_idx == 4'd15);

      case (state_q)
         IDLE: begin
            if (key_sched_start_i) begin
               state_d = GEN;
               mode_d  = key_sched_decrypt_i;
               round_d = '0;
               if (key_sched_decrypt_i) begin
                  // Total encrypt shift is 28, so C16/D16 equal the unrotated halves.
                  c_d = key_sched_key_i[55:28];
                  d_d = key_sched_key_i[27:0];
               end else begin
                  c_d = rotl(key_sched_key_i[55:28], 1'b1);
                  d_d = rotl(key_sched_key_i[27:0], 1'b1);
               end
            end
         end
         GEN: begin
            if (key_sched_ready_i) begin
               if (round_q == 4'd15) begin
                  state_d = IDLE;
                  round_d = '0;
                  done_d  = 1'b1;
               end else begin
                  round_d = next_idx;
                  if (mode_q) begin
                     c_d = rotr(c_q, single_step);
                     d_d = rotr(d_q, single_step);
                  end else begin
                     c_d = rotl(c_q, single_step);
                     d_d = rotl(d_q, single_step);
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cd = {c_q, d_q};

   // PC-2 compression, purely combinational from the C/D registers
   for (genvar g = 0; g < 48; g++) begin : g_pc2
      assign key_sched_subkey_o[47-g] = cd[56-PC2[g]];
   end

   assign key_sched_valid_o = (state_q == GEN);
   assign key_sched_busy_o  = (state_q == GEN);
   assign key_sched_round_o = round_q;
   assign key_sched_done_o  = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: a reference key schedule built from
// cumulative shift totals fills a scoreboard queue, entries are popped on each
// observed handshake.
module tb_des_key_schedule;

   logic        clk;
   logic        rst;
   logic        start;
   logic        dec;
   logic [55:0] key;
   logic        ready;
   logic [47:0] subkey;
   logic        valid;
   logic [3:0]  round;
   logic        busy;
   logic        done;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [51:0] sb [$];
   logic [47:0] obs_first;
   logic [47:0] obs_last;

   localparam logic [55:0] KEY_STD = 56'hF0CCAAF556678F;
   localparam logic [55:0] KEY_ALT = 56'h0123456789ABCD;

   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   localparam int PC2_TB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   des_key_schedule dut (
      .clk                 (clk),
      .rst                 (rst),
      .key_sched_start_i   (start),
      .key_sched_decrypt_i (dec),
      .key_sched_key_i     (key),
      .key_sched_ready_i   (ready),
      .key_sched_subkey_o  (subkey),
      .key_sched_valid_o   (valid),
      .key_sched_round_o   (round),
      .key_sched_busy_o    (busy),
      .key_sched_done_o    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Standard DES subkey K_r (r = 1..16), using 1-based DES bit numbering.
   function automatic logic [47:0] model_subkey(input logic [55:0] k, input int r);
      int          tot;
      int          src;
      logic [55:0] cdm;
      logic [47:0] sk;
      tot = 0;
      for (int i = 0; i < r; i++) tot += SHIFTS[i];
      for (int j = 1; j <= 28; j++) begin
         src               = ((j - 1 + tot) % 28) + 1;
         cdm[56 - j]       = k[56 - src];
         cdm[56 - (28 + j)] = k[56 - (28 + src)];
      end
      for (int i = 1; i <= 48; i++) sk[48 - i] = cdm[56 - PC2_TB[i - 1]];
      return sk;
   endfunction

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; dec = 1'b0; key = '0; ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || round !== 4'd0 || subkey !== 48'h0) begin
         errors++;
         $display("FAIL reset: valid=%b busy=%b done=%b round=%0d subkey=%h, required all zero",
                  valid, busy, done, round, subkey);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Full run with a given ready duty (percent); checks latency, hold under stall,
   // order of subkeys, and a single done pulse.
   task automatic test_sequence(input logic [55:0] k, input logic d, input int pct);
      logic [51:0] e;
      logic [47:0] psub;
      logic [3:0]  prnd;
      logic        stall;
      logic        r;
      int          hs;
      int          cyc;
      sb.delete();
      for (int n = 0; n < 16; n++)
         sb.push_back({4'(n), model_subkey(k, d ? 16 - n : n + 1)});
      @(negedge clk);
      start = 1'b1; dec = d; key = k; ready = 1'b0;
      @(negedge clk);
      start = 1'b0; dec = ~d; key = ~k;
      checks++;
      if (valid !== 1'b1 || round !== 4'd0) begin
         errors++;
         $display("FAIL latency: valid=%b round=%0d, required valid=1 round=0", valid, round);
      end
      hs = 0; cyc = 0; stall = 1'b0; psub = '0; prnd = '0;
      while (hs < 16 && cyc < 400) begin
         if (stall) begin
            checks++;
            if (subkey !== psub || round !== prnd) begin
               errors++;
               $display("FAIL hold: subkey=%h round=%0d, required subkey=%h round=%0d",
                        subkey, round, psub, prnd);
            end
         end
         checks++;
         if (valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL in_gen: valid=%b busy=%b done=%b, required 1 1 0", valid, busy, done);
         end
         r = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
         ready = r;
         if (r) begin
            e = sb.pop_front();
            checks++;
            if ({round, subkey} !== e) begin
               errors++;
               $display("FAIL subkey: round=%0d subkey=%h, required round=%0d subkey=%h",
                        round, subkey, e[51:48], e[47:0]);
            end
            if (hs == 0) obs_first = subkey;
            if (hs == 15) obs_last = subkey;
            hs++;
         end
         stall = !r; psub = subkey; prnd = round;
         @(negedge clk);
         cyc++;
      end
      if (hs < 16) begin
         errors++;
         $display("FAIL timeout: handshakes=%0d, required 16", hs);
      end
      ready = 1'b0;
      checks++;
      if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || round !== 4'd0) begin
         errors++;
         $display("FAIL end: done=%b valid=%b busy=%b round=%0d, required 1 0 0 0",
                  done, valid, busy, round);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_width: done=%b, required 0", done);
      end
   endtask

   task automatic test_encrypt();
      test_sequence(KEY_STD, 1'b0, 100);
      checks++;
      if (obs_first !== 48'h1B02EFFC7072 || obs_last !== 48'hCB3D8B0E17F5) begin
         errors++;
         $display("FAIL enc_known: first=%h last=%h, required 1b02effc7072 cb3d8b0e17f5",
                  obs_first, obs_last);
      end
   endtask

   task automatic test_decrypt();
      test_sequence(KEY_STD, 1'b1, 100);
      checks++;
      if (obs_first !== 48'hCB3D8B0E17F5 || obs_last !== 48'h1B02EFFC7072) begin
         errors++;
         $display("FAIL dec_known: first=%h last=%h, required cb3d8b0e17f5 1b02effc7072",
                  obs_first, obs_last);
      end
   endtask

   task automatic test_backpressure();
      test_sequence(KEY_STD, 1'b0, 40);
      test_sequence(KEY_ALT, 1'b1, 40);
   endtask

   task automatic test_reset_mid();
      int cyc;
      @(negedge clk);
      start = 1'b1; dec = 1'b0; key = KEY_STD; ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (round !== 4'd7 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (round !== 4'd7) begin
         errors++;
         $display("FAIL reach_r7: round=%0d, required 7", round);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (valid !== 1'b0 || busy !== 1'b0 || subkey !== 48'h0 || done !== 1'b0 || round !== 4'd0) begin
         errors++;
         $display("FAIL mid_reset: valid=%b busy=%b done=%b round=%0d subkey=%h, required all zero",
                  valid, busy, done, round, subkey);
      end
      rst = 1'b0; ready = 1'b0;
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_done: done=%b valid=%b, required 0 0", done, valid);
      end
      test_sequence(KEY_STD, 1'b0, 100);
   endtask

   // start held through GEN with key/mode churning; start in the done cycle
   // launches the next run immediately.
   task automatic test_back_to_back();
      logic [47:0] exp;
      @(negedge clk);
      start = 1'b1; dec = 1'b0; key = KEY_STD; ready = 1'b1;
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         key = {24'($urandom), 32'($urandom)};
         dec = 1'($urandom);
         exp = model_subkey(KEY_STD, n + 1);
         checks++;
         if (valid !== 1'b1 || round !== 4'(n) || subkey !== exp) begin
            errors++;
            $display("FAIL held_start: valid=%b round=%0d subkey=%h, required 1 %0d %h",
                     valid, round, subkey, n, exp);
         end
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b1 || valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done: done=%b valid=%b, required 1 0", done, valid);
      end
      key = KEY_ALT; dec = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n < 16; n++) begin
         exp = model_subkey(KEY_ALT, n + 1);
         checks++;
         if (valid !== 1'b1 || done !== 1'b0 || round !== 4'(n) || subkey !== exp) begin
            errors++;
            $display("FAIL b2b_seq: valid=%b done=%b round=%0d subkey=%h, required 1 0 %0d %h",
                     valid, done, round, subkey, n, exp);
         end
         @(negedge clk);
      end
      ready = 1'b0;
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL b2b_done2: done=%b, required 1", done);
      end
      @(negedge clk);
   endtask

   task automatic test_key_corners();
      test_sequence(56'h0, 1'b0, 100);
      checks++;
      if (obs_first !== 48'h0 || obs_last !== 48'h0) begin
         errors++;
         $display("FAIL zero_key: first=%h last=%h, required 0 0", obs_first, obs_last);
      end
      test_sequence(56'hFFFFFFFFFFFFFF, 1'b0, 100);
      checks++;
      if (obs_first !== 48'hFFFFFFFFFFFF || obs_last !== 48'hFFFFFFFFFFFF) begin
         errors++;
         $display("FAIL ones_enc: first=%h last=%h, required all ones", obs_first, obs_last);
      end
      test_sequence(56'hFFFFFFFFFFFFFF, 1'b1, 100);
      checks++;
      if (obs_first !== 48'hFFFFFFFFFFFF || obs_last !== 48'hFFFFFFFFFFFF) begin
         errors++;
         $display("FAIL ones_dec: first=%h last=%h, required all ones", obs_first, obs_last);
      end
   endtask

   initial begin
      test_reset();
      test_encrypt();
      test_decrypt();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_key_corners();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
